// File: rtl/uart_echo_fifo.sv
// Receive-to-transmit echo buffer: a circular FIFO fills from UART receive strobes
// and a three-state drain FSM feeds bytes one at a time to a busy-handshaking transmitter.
module uart_echo_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_ready,
  input  logic                     tx_busy,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     tx_start,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e          state_q;
  logic [WIDTH-1:0] tx_data_q;
  logic            tx_start_q;

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            run_q;

  logic [WIDTH-1:0] mem [DEPTH];

  logic full_w, empty_w;
  logic push, drop, pop;

  // run_q blocks all pushes and pops on the first edge after reset release.
  always_comb begin
    full_w   = (count_q == CW'(DEPTH));
    empty_w  = (count_q == '0);
    push     = run_q && rx_ready && !full_w;
    drop     = run_q && rx_ready && full_w;
    pop      = run_q && (state_q == S_IDLE) && !empty_w && !tx_busy;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      run_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= rx_data;
    end
  end

  // HOLD gives the transmitter one cycle to raise tx_busy before WAIT samples it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            tx_data_q  <= mem[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= S_HOLD;
          end
        end
        S_HOLD: state_q <= S_WAIT;
        S_WAIT: begin
          if (!tx_busy) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign count    = count_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: directed vector table, corner sequences and randomized
// traffic compared cycle by cycle against a queue-based reference with a busy transmitter.
module tb_uart_echo_fifo;

  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] rx_data;
  logic             rx_ready;
  logic             tx_busy;
  logic [WIDTH-1:0] tx_data;
  logic             tx_start;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             ovf_clr;

  always #5 clk = ~clk;

  uart_echo_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus the drain timing rules expressed as
  // "edges since the last pop" and "busy seen low at least two edges after it".
  logic [7:0] byte_q [$];
  bit         ovf_m;
  bit         low_seen;
  int         since_pop;
  bit         armed;
  logic [7:0] last_tx;
  int         starts;
  int         pushed;
  bit         prev_start;
  int         busy_rem;
  int         busy_len;
  bit         start_pending;
  bit         force_busy;

  task automatic step(input bit rdy, input logic [7:0] d, input bit clr);
    bit busy_now;
    bit pop_exp;
    bit drop;
    int size_pre;
    rx_ready = rdy;
    rx_data  = d;
    ovf_clr  = clr;
    busy_now = force_busy || (busy_rem > 0);
    if (busy_rem > 0) busy_rem--;
    if (start_pending) begin
      busy_rem      = busy_len;
      start_pending = 1'b0;
    end
    tx_busy  = busy_now;
    size_pre = byte_q.size();
    pop_exp  = armed && low_seen && (size_pre > 0) && !busy_now;
    drop     = armed && rdy && (size_pre == DEPTH);
    if (armed && rdy && !drop) begin
      byte_q.push_back(d);
      pushed++;
    end
    if (drop) ovf_m = 1'b1;
    else if (clr) ovf_m = 1'b0;
    if (pop_exp) begin
      since_pop = 1;
      low_seen  = 1'b0;
    end else begin
      if (since_pop >= 2 && !busy_now) low_seen = 1'b1;
      since_pop++;
    end
    armed = 1'b1;

    @(posedge clk);
    #1;
    chk("tx_start", tx_start, pop_exp);
    chk("no_back_to_back", tx_start && prev_start, 0);
    if (pop_exp) begin
      last_tx = byte_q.pop_front();
      starts++;
    end
    chk("tx_data", tx_data, last_tx);
    chk("count", count, byte_q.size());
    chk("empty", empty, byte_q.size() == 0);
    chk("full", full, byte_q.size() == DEPTH);
    chk("overflow", overflow, ovf_m);
    start_pending = tx_start;
    prev_start    = tx_start;
  endtask

  task automatic do_reset();
    rx_ready = 1'b0;
    rx_data  = '0;
    ovf_clr  = 1'b0;
    tx_busy  = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    byte_q.delete();
    ovf_m         = 1'b0;
    low_seen      = 1'b1;
    since_pop     = 100;
    armed         = 1'b0;
    last_tx       = 8'h00;
    starts        = 0;
    pushed        = 0;
    prev_start    = 1'b0;
    busy_rem      = 0;
    start_pending = 1'b0;
    force_busy    = 1'b0;
    step(1'b0, 8'h00, 1'b0);
  endtask

  typedef struct {
    bit         rdy;
    logic [7:0] d;
    bit         busy;
    bit         clr;
    int         cnt;
    bit         st;
    logic [7:0] txd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // Expected values after each edge, worked out from the drain rules by hand.
    tbl[0]  = '{1'b1, 8'h41, 1'b0, 1'b0, 1, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'h41};
    tbl[2]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1, 1'b0, 8'h41};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h41};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h41};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'h41};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'h5A};
    tbl[7]  = '{1'b1, 8'hC3, 1'b0, 1'b0, 1, 1'b0, 8'h5A};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 8'h5A};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h5A};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 8'hC3};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'hC3};

    rst_n    = 1'b1;
    busy_len = 0;
    #2;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      rx_ready = tbl[i].rdy;
      rx_data  = tbl[i].d;
      tx_busy  = tbl[i].busy;
      ovf_clr  = tbl[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_count", i), count, tbl[i].cnt);
      chk($sformatf("vec%0d_tx_start", i), tx_start, tbl[i].st);
      chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].txd);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].cnt == 0);
      chk($sformatf("vec%0d_overflow", i), overflow, 0);
    end

    // Burst into a slow transmitter.
    do_reset();
    busy_len = 217;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(i);
      step(1'b1, b, 1'b0);
    end
    repeat (16 * 225) step(1'b0, 8'h00, 1'b0);
    chk("burst_starts", starts, 16);
    chk("burst_count", count, 0);
    chk("burst_overflow", overflow, 0);

    // Overflow with a stalled transmitter.
    do_reset();
    force_busy = 1'b1;
    busy_len   = 3;
    for (int i = 0; i < 17; i++) step(1'b1, 8'($urandom), 1'b0);
    chk("ovf_full", full, 1);
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    step(1'b1, 8'hEE, 1'b1);
    chk("ovf_set_wins", overflow, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", overflow, 0);
    force_busy = 1'b0;
    repeat (200) step(1'b0, 8'h00, 1'b0);
    chk("ovf_drained_starts", starts, 16);
    chk("ovf_drained_count", count, 0);

    // Simultaneous push and pop at count 5.
    do_reset();
    force_busy = 1'b1;
    busy_len   = 2;
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    force_busy = 1'b0;
    step(1'b1, 8'($urandom), 1'b0);
    chk("simul_count", count, 5);
    chk("simul_start", tx_start, 1);
    step(1'b0, 8'h00, 1'b0);
    chk("simul_single_start", tx_start, 0);
    repeat (100) step(1'b0, 8'h00, 1'b0);
    chk("simul_drained", count, 0);

    // Randomized traffic with wrap-around.
    do_reset();
    busy_len = 2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) busy_len = $urandom_range(0, 3);
      step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 49) == 0);
    end
    repeat (300) step(1'b0, 8'h00, 1'b0);
    chk("rand_count_zero", count, 0);
    chk("rand_all_sent", starts, pushed);
    chk("rand_enough_traffic", pushed >= 40, 1);

    // Reset in the middle of a transfer.
    do_reset();
    busy_len = 217;
    for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom), 1'b0);
    chk("mid_count7", count, 7);
    do_reset();
    repeat (40) step(1'b0, 8'h00, 1'b0);
    chk("mid_no_start", starts, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_echo_fifo.md
UART_ECHO_FIFO -- requirements
Module: uart_echo_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, 2..256.
REQ-002 Parameter WIDTH, default 8, bits per entry.
REQ-003 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  WIDTH  received byte from the UART receiver.
REQ-006 rx_ready  input  1  one-cycle strobe; rx_data valid in the same cycle.
REQ-007 tx_busy  input  1  UART transmitter busy.
REQ-008 tx_data  output  WIDTH  byte presented to the transmitter; registered.
REQ-009 tx_start  output  1  one-cycle transmit request; registered.
REQ-010 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-011 empty  output  1  count == 0.
REQ-012 full  output  1  count == DEPTH.
REQ-013 overflow  output  1  sticky flag: a byte was dropped.
REQ-014 ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-015 Storage SHALL be a circular buffer with a write pointer and a read pointer of $clog2(DEPTH) bits each; both SHALL wrap from DEPTH-1 to 0.
REQ-016 Push: on rx_ready with full=0, store rx_data at wr_ptr, wr_ptr+1.
REQ-017 Push on a full FIFO: drop the byte, no pointer or count change, set overflow; full is evaluated before any same-cycle pop.
REQ-018 Drain FSM states are IDLE, HOLD and WAIT.
REQ-019 IDLE: if empty=0 and tx_busy=0, pop the entry at rd_ptr into tx_data, rd_ptr+1, tx_start=1 for exactly one cycle, go to HOLD; otherwise stay in IDLE with tx_start=0.
REQ-020 HOLD: one cycle, no action, go to WAIT; this gives the transmitter one cycle to raise tx_busy.
REQ-021 WAIT: stay while tx_busy=1; go to IDLE in the cycle after tx_busy is sampled low.
REQ-022 Simultaneous push and pop with full=0: both happen and count is unchanged.
REQ-023 Push to an empty FIFO with the FSM in IDLE and tx_busy=0: count=1 after edge k; tx_start high after edge k+1; no bypass path.
REQ-024 tx_data SHALL hold its value between pops.
REQ-025 Byte order out SHALL equal byte order in; no byte duplicated or reordered.
REQ-026 ovf_clr asserted together with a dropping push: overflow SHALL remain 1 (set wins).
REQ-027 count SHALL never exceed DEPTH nor underflow below 0.
REQ-028 tx_start SHALL never be asserted in two consecutive cycles.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force all of the following: pointers 0, count 0, empty 1, full 0, overflow 0, tx_start 0, tx_data 0, FSM IDLE.
REQ-030 Reset mid-transfer SHALL discard all stored bytes; storage array contents need not be reset.
REQ-031 Release of rst_n SHALL be synchronous to clk externally; no push or pop occurs in the first cycle after release.

Verification
REQ-032 Single byte: push 0x41 with tx_busy=0 -> tx_start pulse 2 cycles later, tx_data=0x41, count back to 0, empty=1.
REQ-033 Burst with a slow transmitter (model: tx_busy high from the cycle after tx_start for 217 cycles): push 0x00..0x0F back-to-back -> 16 tx_start pulses, tx_data sequence 0x00..0x0F in order, overflow=0.
REQ-034 Overflow (DEPTH=16): hold tx_busy=1 and push 17 bytes -> full=1, count=16, overflow=1, 17th byte never transmitted; ovf_clr -> overflow=0.
REQ-035 Wrap-around: 40 push/drain cycles with random data -> output stream matches input stream, count returns to 0.
REQ-036 Simultaneous push/pop at count=5 -> count stays 5, tx_start asserted once.
REQ-037 Reset mid-operation: assert rst_n low with count=7 while the FSM is in WAIT -> outputs take their reset values immediately; after release with no push, no tx_start is ever asserted.
